// File: rtl/fpu_issuer.sv
// Initiator front end for the fpu start/done handshake: one command in flight,
// result returned on a valid/ready response port. Optional ISSUE watchdog: FPU_ISSUER_TIMEOUT_EN.
module fpu_issuer #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic             fpu_start,
    output logic [1:0]       fpu_op,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [1:0]       rsp_op,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] ops_count
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_done;
    logic             cmd_fire;
    logic             tmo_hit;

    if (GAP_CYCLES < 1) begin : g_gap_chk
        $error("fpu_issuer: GAP_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("fpu_issuer: TIMEOUT_CYCLES must be at least 1");
    end

    assign cmd_fire = (state == IDLE) && cmd_valid && cmd_ready;
    assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

`ifdef FPU_ISSUER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts ISSUE cycles; held at zero elsewhere so it restarts on every issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state != ISSUE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (state == ISSUE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A done still high after the gap count keeps us in GAP until it falls.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire)                 state_nxt = ISSUE;
            ISSUE:   if (fpu_done || tmo_hit)      state_nxt = GAP;
            GAP:     if (gap_done && !fpu_done)    state_nxt = RESP;
            RESP:    if (rsp_ready)                state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready <= 1'b0;
            fpu_start <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            fpu_start <= (state_nxt == ISSUE);
            rsp_valid <= (state_nxt == RESP);
            busy      <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpu_op      <= '0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            rsp_op      <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            ops_count   <= '0;
            gap_cnt     <= '0;
        end else begin
            if (cmd_fire) begin
                fpu_op <= cmd_op;
                fpu_a  <= cmd_a;
                fpu_b  <= cmd_b;
                rsp_op <= cmd_op;
            end

            // A done in the watchdog's terminal cycle takes priority over the abort.
            if (state == ISSUE && fpu_done) begin
                rsp_data    <= fpu_r;
                rsp_timeout <= 1'b0;
            end else if (tmo_hit) begin
                rsp_data    <= QNAN;
                rsp_timeout <= 1'b1;
            end

            if (state == RESP && rsp_ready) begin
                ops_count <= ops_count + CNT_W'(1);
            end

            if (state != GAP) begin
                gap_cnt <= '0;
            end else if (!gap_done) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule
